alu_seq: RTL and testbench

- Execute stage that sits directly upstream of the 16x8 register file.
- Consumes the accumulator (R0), the operand register and the status register read ports; produces the write-back data, address, flag and write enable that the register file captures.
- Single-cycle ops (add/sub/logic) complete in one cycle; shifts and multiply iterate one bit per cycle behind an issue/busy/done handshake.

---
 rtl/alu_seq.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential execute stage feeding the 16x8 register file: single-cycle ALU ops,
// iterative shifts, optional shift-add multiply (enabled by `define ALU_SEQ_MUL_EN).
//
// state | meaning
// IDLE  | waiting for issue; operands are captured on the accepting edge
// ITER  | one shift / multiply step per cycle, cnt_q counts remaining steps
// WB    | done pulse; register-file write for legal ops
module alu_seq #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue,
    input  logic [3:0]    op,
    input  logic [AW-1:0] dst,
    input  logic [W-1:0]  acc_in,
    input  logic [W-1:0]  opr_in,
    input  logic [W-1:0]  status_in,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  dat_out,
    output logic          flag_out
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_WB} state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [W-1:0]    res_q, res_d;
    logic            flag_q, flag_d;
    logic [3:0]      cnt_q, cnt_d;
`ifdef ALU_SEQ_MUL_EN
    logic [2*W-1:0]  prod_q, prod_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W:0]      mul_sum;
`endif

    logic [W:0]      sum_w;
    logic [W:0]      diff_w;
    logic            cin_sel;
    logic [W-1:0]    alu_res;
    logic            alu_flag;
    logic            is_shift_in;
    logic            is_mul_in;
    logic            goes_iter;
    logic [3:0]      load_cnt;
    logic            legal_q;
    logic            unused_status;

    assign unused_status = ^status_in[W-1:1];

    assign is_shift_in = (op == OP_SHL) || (op == OP_SHR);
`ifdef ALU_SEQ_MUL_EN
    assign is_mul_in = (op == OP_MUL);
    assign legal_q   = (op_q <= OP_MUL);
`else
    assign is_mul_in = 1'b0;
    assign legal_q   = (op_q <= OP_SHR);
`endif
    assign goes_iter = (is_shift_in && (opr_in[2:0] != 3'd0)) || is_mul_in;
    assign load_cnt  = is_mul_in ? 4'd8 : (is_shift_in ? {1'b0, opr_in[2:0]} : 4'd0);

    // Single-cycle results; shifts start from acc with a cleared flag so amount 0 retires as-is
    always_comb begin
        cin_sel  = (op == OP_ADC) & status_in[0];
        sum_w    = {1'b0, acc_in} + {1'b0, opr_in} + {{W{1'b0}}, cin_sel};
        diff_w   = {1'b0, acc_in} - {1'b0, opr_in};
        alu_res  = '0;
        alu_flag = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                alu_res  = sum_w[W-1:0];
                alu_flag = sum_w[W];
            end
            OP_SUB: begin
                alu_res  = diff_w[W-1:0];
                alu_flag = diff_w[W];
            end
            OP_AND: begin
                alu_res  = acc_in & opr_in;
                alu_flag = ~|(acc_in & opr_in);
            end
            OP_OR: begin
                alu_res  = acc_in | opr_in;
                alu_flag = ~|(acc_in | opr_in);
            end
            OP_XOR: begin
                alu_res  = acc_in ^ opr_in;
                alu_flag = ~|(acc_in ^ opr_in);
            end
            OP_SHL, OP_SHR: alu_res = acc_in;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue) state_d = goes_iter ? S_ITER : S_WB;
            S_ITER: if (cnt_q == 4'd1) state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_WB);
        wr_en    = (state_q == S_WB) && legal_q;
        wr_addr  = wr_en ? dst_q : '0;
        dat_out  = wr_en ? res_q : '0;
        flag_out = wr_en & flag_q;
    end

    always_comb begin
        op_d    = op_q;
        dst_d   = dst_q;
        res_d   = res_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
`ifdef ALU_SEQ_MUL_EN
        prod_d  = prod_q;
        mcand_d = mcand_q;
        mul_sum = '0;
`endif
        case (state_q)
            S_IDLE: if (issue) begin
                op_d   = op;
                dst_d  = dst;
                res_d  = alu_res;
                flag_d = alu_flag;
                cnt_d  = load_cnt;
`ifdef ALU_SEQ_MUL_EN
                prod_d  = {{W{1'b0}}, opr_in};
                mcand_d = acc_in;
`endif
            end
            S_ITER: begin
                cnt_d = cnt_q - 4'd1;
                if (op_q == OP_SHL) begin
                    flag_d = res_q[W-1];
                    res_d  = {res_q[W-2:0], 1'b0};
                end else if (op_q == OP_SHR) begin
                    flag_d = res_q[0];
                    res_d  = {1'b0, res_q[W-1:1]};
                end
`ifdef ALU_SEQ_MUL_EN
                else begin
                    // multiplier sits in the low half and drains out as partial sums shift in
                    mul_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
                    prod_d  = {mul_sum, prod_q[W-1:1]};
                    res_d   = prod_d[W-1:0];
                    flag_d  = |prod_d[2*W-1:W];
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            dst_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= '0;
            mcand_q <= '0;
`endif
        end else begin
            op_q    <= op_d;
            dst_q   <= dst_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected write-backs are queued at issue and
// matched by a monitor on each done pulse; works with or without ALU_SEQ_MUL_EN.
module tb_alu_seq;
    localparam int W  = 8;
    localparam int AW = 4;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issue = 1'b0;
    logic [3:0]    op = '0;
    logic [AW-1:0] dst = '0;
    logic [W-1:0]  acc_in = '0;
    logic [W-1:0]  opr_in = '0;
    logic [W-1:0]  status_in = '0;
    logic          busy, done, wr_en, flag_out;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  dat_out;

    alu_seq #(.W(W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .issue(issue), .op(op), .dst(dst),
        .acc_in(acc_in), .opr_in(opr_in), .status_in(status_in),
        .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr),
        .dat_out(dat_out), .flag_out(flag_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int op;
        int addr;
        int data;
        int flag;
        bit wr;
        int due;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference behaviour from the arithmetic definitions, with retire latency
    function automatic exp_t model(input int o, input int d, input int a, input int b,
                                   input int cin, input int issue_cyc);
        exp_t e;
        int k, s, p, lat;
        k = b % 8;
        e.op = o; e.addr = d; e.wr = 1'b1; e.data = 0; e.flag = 0;
        lat = 1;
        case (o)
            0: begin s = a + b;       e.data = s % 256; e.flag = (s > 255); end
            1: begin s = a + b + cin; e.data = s % 256; e.flag = (s > 255); end
            2: begin e.data = (a - b + 256) % 256; e.flag = (a < b); end
            3: begin e.data = a & b; e.flag = (e.data == 0); end
            4: begin e.data = a | b; e.flag = (e.data == 0); end
            5: begin e.data = a ^ b; e.flag = (e.data == 0); end
            6: begin
                e.data = (a * (1 << k)) % 256;
                e.flag = (k == 0) ? 0 : (a / (1 << (8 - k))) % 2;
                lat = k + 1;
            end
            7: begin
                e.data = a / (1 << k);
                e.flag = (k == 0) ? 0 : (a / (1 << (k - 1))) % 2;
                lat = k + 1;
            end
            8: begin
                if (MUL_ON) begin
                    p = a * b;
                    e.data = p % 256;
                    e.flag = (p / 256) != 0;
                    lat = 9;
                end else begin
                    e.wr = 1'b0;
                end
            end
            default: e.wr = 1'b0;
        endcase
        e.due = issue_cyc + lat;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (wr_en) chk("wr_en_with_done", int'(done), 1);
            if (done) begin
                chk("done_expected", int'(sbq.size() > 0), 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("busy_in_wb", int'(busy), 1);
                    chk("latency", cyc, e.due);
                    chk("wr_en", int'(wr_en), int'(e.wr));
                    if (e.wr) begin
                        chk("wr_addr", int'(wr_addr), e.addr);
                        chk("dat_out", int'(dat_out), e.data);
                        chk("flag_out", int'(flag_out), e.flag);
                    end
                end
            end
        end
    end

    task automatic scramble();
        acc_in    = W'($urandom);
        opr_in    = W'($urandom);
        status_in = W'($urandom);
    endtask

    // Waits for idle, drives issue for `hold` rising edges, queues the one expected retire
    task automatic issue_op(input int o, input int d, input int a, input int b,
                            input int st, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            scramble();
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("idle_timeout", int'(busy), 0);
        end else begin
            op        = 4'(o);
            dst       = AW'(d);
            acc_in    = W'(a);
            opr_in    = W'(b);
            status_in = W'(st);
            issue     = 1'b1;
            sbq.push_back(model(o, d, a, b, st % 2, cyc));
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                scramble();
            end
            issue = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int o, k;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_dat_out", int'(dat_out), 0);
        chk("rst_flag_out", int'(flag_out), 0);
        rst_n = 1'b1;

        // Abort a long op with reset; nothing may retire afterwards
        issue_op(MUL_ON ? 8 : 6, 3, 8'h10, MUL_ON ? 8'h11 : 8'h07, 0, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_done", int'(done), 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        issue_op(0, 5, 8'hF0, 8'h20, 8'h00, 1);
        issue_op(1, 6, 8'h01, 8'h01, 8'h01, 1);
        issue_op(2, 7, 8'h05, 8'h07, 8'h00, 1);
        issue_op(5, 8, 8'h5A, 8'h5A, 8'h00, 1);
        issue_op(6, 9, 8'h81, 8'h03, 8'h00, 1);
        issue_op(7, 10, 8'h81, 8'h01, 8'h00, 1);
        issue_op(6, 11, 8'h81, 8'h00, 8'h00, 1);
        issue_op(8, 12, 8'h10, 8'h11, 8'h00, 1);
        issue_op(4'hC, 13, 8'h33, 8'h44, 8'h00, 1);
        drain();

        // issue held through the whole op including its WB cycle: exactly one retire
        issue_op(6, 14, 8'hC3, 8'h07, 8'h00, 9);
        if (MUL_ON) issue_op(8, 15, 8'hFF, 8'hFF, 8'h00, 10);
        drain();
        repeat (4) @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) o = $urandom_range(9, 15);
            else                           o = $urandom_range(0, 8);
            k = $urandom_range(0, 255);
            issue_op(o, $urandom_range(0, 15), $urandom_range(0, 255), k,
                     $urandom_range(0, 255), 1);
        end
        drain();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
